// File: rtl/precision_cfg_loader_if.sv
// Config-word handshake bundle between a producer (master) and the loader (slave).
interface precision_cfg_loader_if #(
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_in_signed;
    logic [3:0]       cfg_weight_signed;
    logic [CNT_W-1:0] cfg_count;

    modport master (
        output cfg_valid,
        output cfg_in_signed,
        output cfg_weight_signed,
        output cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_in_signed,
        input  cfg_weight_signed,
        input  cfg_count,
        output cfg_ready
    );
endinterface

// File: rtl/precision_cfg_loader.sv
// Two-slot (active + pending) layer precision loader. Decodes per-brick sign
// masks into one-hot operand widths, counts down the layer's compute steps and
// keeps sticky error flags for malformed words and stray steps.
module precision_cfg_loader #(
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    precision_cfg_loader_if.slave      cfg,
    input  logic                       step,
    input  logic                       err_clear,
    output logic                       active_valid,
    output logic [3:0]                 in_width,
    output logic [3:0]                 weight_width,
    output logic [CNT_W-1:0]           remaining,
    output logic                       layer_done,
    output logic [3:0]                 err_code
);

    logic             active_valid_q, active_valid_d;
    logic [3:0]       in_width_q, in_width_d;
    logic [3:0]       weight_width_q, weight_width_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             pend_full_q, pend_full_d;
    logic [3:0]       pend_in_q, pend_in_d;
    logic [3:0]       pend_wt_q, pend_wt_d;
    logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic             layer_done_q, layer_done_d;
    logic [3:0]       err_code_q, err_code_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic [3:0] dec_in, dec_wt;
    logic       hs, legal, finish, active_free;

    // Mask decode: only the three brick groupings map to a width; zero means illegal.
    always_comb begin
        dec_in = 4'b0000;
        case (cfg.cfg_in_signed)
            4'b1111: dec_in = 4'b0010;
            4'b1010: dec_in = 4'b0100;
            4'b1000: dec_in = 4'b1000;
            default: dec_in = 4'b0000;
        endcase
        dec_wt = 4'b0000;
        case (cfg.cfg_weight_signed)
            4'b1111: dec_wt = 4'b0010;
            4'b1010: dec_wt = 4'b0100;
            4'b1000: dec_wt = 4'b1000;
            default: dec_wt = 4'b0000;
        endcase
    end

    // Slot bookkeeping: decide where an accepted word lands and how the active layer advances.
    always_comb begin
        hs          = cfg.cfg_valid && cfg_ready_q;
        legal       = (dec_in != 4'b0000) && (dec_wt != 4'b0000) && (cfg.cfg_count != '0);
        finish      = step && active_valid_q && (remaining_q == CNT_W'(1));
        active_free = !active_valid_q || (finish && !pend_full_q);

        active_valid_d = active_valid_q;
        in_width_d     = in_width_q;
        weight_width_d = weight_width_q;
        remaining_d    = remaining_q;
        pend_full_d    = pend_full_q;
        pend_in_d      = pend_in_q;
        pend_wt_d      = pend_wt_q;
        pend_cnt_d     = pend_cnt_q;
        layer_done_d   = finish;

        if (finish) begin
            // Outputs must read zero while idle, so a finishing layer clears its fields.
            active_valid_d = 1'b0;
            in_width_d     = 4'b0000;
            weight_width_d = 4'b0000;
            remaining_d    = '0;
            if (pend_full_q) begin
                active_valid_d = 1'b1;
                in_width_d     = pend_in_q;
                weight_width_d = pend_wt_q;
                remaining_d    = pend_cnt_q;
                pend_full_d    = 1'b0;
            end
        end else if (step && active_valid_q) begin
            remaining_d = remaining_q - CNT_W'(1);
        end

        if (hs && legal) begin
            if (active_free) begin
                active_valid_d = 1'b1;
                in_width_d     = dec_in;
                weight_width_d = dec_wt;
                remaining_d    = cfg.cfg_count;
            end else begin
                pend_full_d = 1'b1;
                pend_in_d   = dec_in;
                pend_wt_d   = dec_wt;
                pend_cnt_d  = cfg.cfg_count;
            end
        end

        cfg_ready_d = !pend_full_d;

        // Clear first so a flag raised at the same edge survives the clear.
        err_code_d = err_clear ? 4'b0000 : err_code_q;
        if (hs && !legal) begin
            if (dec_in == 4'b0000)      err_code_d[0] = 1'b1;
            if (dec_wt == 4'b0000)      err_code_d[1] = 1'b1;
            if (cfg.cfg_count == '0)    err_code_d[2] = 1'b1;
        end
        if (step && !active_valid_q) err_code_d[3] = 1'b1;
    end

    // State registers with synchronous reset that overrides every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_valid_q <= 1'b0;
            in_width_q     <= 4'b0000;
            weight_width_q <= 4'b0000;
            remaining_q    <= '0;
            pend_full_q    <= 1'b0;
            pend_in_q      <= 4'b0000;
            pend_wt_q      <= 4'b0000;
            pend_cnt_q     <= '0;
            layer_done_q   <= 1'b0;
            err_code_q     <= 4'b0000;
            cfg_ready_q    <= 1'b0;
        end else begin
            active_valid_q <= active_valid_d;
            in_width_q     <= in_width_d;
            weight_width_q <= weight_width_d;
            remaining_q    <= remaining_d;
            pend_full_q    <= pend_full_d;
            pend_in_q      <= pend_in_d;
            pend_wt_q      <= pend_wt_d;
            pend_cnt_q     <= pend_cnt_d;
            layer_done_q   <= layer_done_d;
            err_code_q     <= err_code_d;
            cfg_ready_q    <= cfg_ready_d;
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        cfg.cfg_ready = cfg_ready_q;
        active_valid  = active_valid_q;
        in_width      = in_width_q;
        weight_width  = weight_width_q;
        remaining     = remaining_q;
        layer_done    = layer_done_q;
        err_code      = err_code_q;
    end

endmodule

// File: tb/tb_precision_cfg_loader.sv
// Directed bench for precision_cfg_loader: one task per scenario, inline checks.
module tb_precision_cfg_loader;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             step;
    logic             err_clear;
    logic             active_valid;
    logic [3:0]       in_width;
    logic [3:0]       weight_width;
    logic [CNT_W-1:0] remaining;
    logic             layer_done;
    logic [3:0]       err_code;

    int passed = 0;
    int total  = 0;

    precision_cfg_loader_if #(.CNT_W(CNT_W)) cfg_if ();

    precision_cfg_loader #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg          (cfg_if.slave),
        .step         (step),
        .err_clear    (err_clear),
        .active_valid (active_valid),
        .in_width     (in_width),
        .weight_width (weight_width),
        .remaining    (remaining),
        .layer_done   (layer_done),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are then driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] im, input logic [3:0] wm, input logic [CNT_W-1:0] c);
        cfg_if.cfg_valid         = 1'b1;
        cfg_if.cfg_in_signed     = im;
        cfg_if.cfg_weight_signed = wm;
        cfg_if.cfg_count         = c;
    endtask

    task automatic idle_inputs();
        cfg_if.cfg_valid         = 1'b0;
        cfg_if.cfg_in_signed     = 4'b0000;
        cfg_if.cfg_weight_signed = 4'b0000;
        cfg_if.cfg_count         = '0;
        step      = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        total++; if (active_valid !== 1'b0) $display("FAIL rst_av got %b exp 0", active_valid); else passed++;
        total++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", cfg_if.cfg_ready); else passed++;
        total++; if ({in_width, weight_width, remaining} !== 24'h0) $display("FAIL rst_fields got %h exp 0", {in_width, weight_width, remaining}); else passed++;
        total++; if ({layer_done, err_code} !== 5'b0) $display("FAIL rst_done_err got %b exp 00000", {layer_done, err_code}); else passed++;
        reset = 1'b0;
        tick();
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", cfg_if.cfg_ready); else passed++;
    endtask

    task automatic test_single_layer();
        offer(4'b1010, 4'b1000, 16'd3);
        tick();
        idle_inputs();
        total++; if (active_valid !== 1'b1) $display("FAIL single_av got %b exp 1", active_valid); else passed++;
        total++; if (in_width !== 4'b0100) $display("FAIL single_in got %b exp 0100", in_width); else passed++;
        total++; if (weight_width !== 4'b1000) $display("FAIL single_wt got %b exp 1000", weight_width); else passed++;
        total++; if (remaining !== 16'd3) $display("FAIL single_rem0 got %0d exp 3", remaining); else passed++;
        step = 1'b1;
        tick();
        total++; if (remaining !== 16'd2) $display("FAIL single_rem1 got %0d exp 2", remaining); else passed++;
        total++; if (layer_done !== 1'b0) $display("FAIL single_early_done got %b exp 0", layer_done); else passed++;
        tick();
        total++; if (remaining !== 16'd1) $display("FAIL single_rem2 got %0d exp 1", remaining); else passed++;
        tick();
        step = 1'b0;
        total++; if (active_valid !== 1'b0) $display("FAIL single_av_end got %b exp 0", active_valid); else passed++;
        total++; if (layer_done !== 1'b1) $display("FAIL single_done got %b exp 1", layer_done); else passed++;
        total++; if ({in_width, weight_width, remaining} !== 24'h0) $display("FAIL single_idle_fields got %h exp 0", {in_width, weight_width, remaining}); else passed++;
        tick();
        total++; if (layer_done !== 1'b0) $display("FAIL single_done_pulse got %b exp 0", layer_done); else passed++;
        total++; if (err_code !== 4'b0000) $display("FAIL single_err got %b exp 0000", err_code); else passed++;
    endtask

    task automatic test_back_to_back();
        offer(4'b1111, 4'b1111, 16'd1);
        tick();
        offer(4'b1000, 4'b1010, 16'd2);
        tick();
        idle_inputs();
        total++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL b2b_ready_wait got %b exp 0", cfg_if.cfg_ready); else passed++;
        total++; if ({active_valid, in_width, weight_width, remaining} !== {1'b1, 4'b0010, 4'b0010, 16'd1}) $display("FAIL b2b_a_active got %h exp %h", {active_valid, in_width, weight_width, remaining}, {1'b1, 4'b0010, 4'b0010, 16'd1}); else passed++;
        step = 1'b1;
        tick();
        step = 1'b0;
        total++; if ({active_valid, in_width, weight_width, remaining} !== {1'b1, 4'b1000, 4'b0100, 16'd2}) $display("FAIL b2b_swap got %h exp %h", {active_valid, in_width, weight_width, remaining}, {1'b1, 4'b1000, 4'b0100, 16'd2}); else passed++;
        total++; if (layer_done !== 1'b1) $display("FAIL b2b_done_a got %b exp 1", layer_done); else passed++;
        total++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL b2b_ready_free got %b exp 1", cfg_if.cfg_ready); else passed++;
        step = 1'b1;
        tick(); tick();
        step = 1'b0;
        total++; if ({active_valid, remaining, layer_done} !== {1'b0, 16'd0, 1'b1}) $display("FAIL b2b_drain got %h exp %h", {active_valid, remaining, layer_done}, {1'b0, 16'd0, 1'b1}); else passed++;
        tick();
    endtask

    task automatic test_finish_direct();
        offer(4'b1111, 4'b1000, 16'd1);
        tick();
        offer(4'b1010, 4'b1111, 16'd4);
        step = 1'b1;
        tick();
        idle_inputs();
        total++; if ({active_valid, in_width, weight_width, remaining} !== {1'b1, 4'b0100, 4'b0010, 16'd4}) $display("FAIL direct_load got %h exp %h", {active_valid, in_width, weight_width, remaining}, {1'b1, 4'b0100, 4'b0010, 16'd4}); else passed++;
        total++; if ({layer_done, cfg_if.cfg_ready} !== 2'b11) $display("FAIL direct_done_ready got %b exp 11", {layer_done, cfg_if.cfg_ready}); else passed++;
        step = 1'b1;
        tick(); tick(); tick(); tick();
        step = 1'b0;
        total++; if ({active_valid, layer_done} !== 2'b01) $display("FAIL direct_drain got %b exp 01", {active_valid, layer_done}); else passed++;
        tick();
    endtask

    task automatic test_illegal();
        offer(4'b0110, 4'b1111, 16'd1);
        tick();
        total++; if (err_code !== 4'b0001) $display("FAIL ill_in got %b exp 0001", err_code); else passed++;
        total++; if ({active_valid, cfg_if.cfg_ready} !== 2'b01) $display("FAIL ill_noload got %b exp 01", {active_valid, cfg_if.cfg_ready}); else passed++;
        offer(4'b1111, 4'b0000, 16'd1);
        tick();
        total++; if (err_code !== 4'b0011) $display("FAIL ill_wt got %b exp 0011", err_code); else passed++;
        offer(4'b1111, 4'b1111, 16'd0);
        tick();
        idle_inputs();
        total++; if (err_code !== 4'b0111) $display("FAIL ill_cnt got %b exp 0111", err_code); else passed++;
        total++; if ({active_valid, remaining, cfg_if.cfg_ready} !== {1'b0, 16'd0, 1'b1}) $display("FAIL ill_state got %h exp %h", {active_valid, remaining, cfg_if.cfg_ready}, {1'b0, 16'd0, 1'b1}); else passed++;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        total++; if (err_code !== 4'b0000) $display("FAIL ill_clear got %b exp 0000", err_code); else passed++;
    endtask

    task automatic test_idle_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        total++; if (err_code !== 4'b1000) $display("FAIL idle_step_err got %b exp 1000", err_code); else passed++;
        total++; if ({active_valid, remaining, layer_done} !== {1'b0, 16'd0, 1'b0}) $display("FAIL idle_step_state got %h exp 0", {active_valid, remaining, layer_done}); else passed++;
        err_clear = 1'b1;
        offer(4'b0001, 4'b1111, 16'd2);
        tick();
        idle_inputs();
        total++; if (err_code !== 4'b0001) $display("FAIL clear_vs_set got %b exp 0001", err_code); else passed++;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    task automatic test_reset_mid_layer();
        offer(4'b1111, 4'b1111, 16'd5);
        tick();
        offer(4'b1000, 4'b1000, 16'd2);
        tick();
        idle_inputs();
        total++; if ({remaining, cfg_if.cfg_ready} !== {16'd5, 1'b0}) $display("FAIL mid_setup got %h exp %h", {remaining, cfg_if.cfg_ready}, {16'd5, 1'b0}); else passed++;
        reset = 1'b1;
        step  = 1'b1;
        offer(4'b1010, 4'b1010, 16'd7);
        tick();
        idle_inputs();
        total++; if ({active_valid, in_width, weight_width, remaining, layer_done, err_code, cfg_if.cfg_ready} !== 31'h0) $display("FAIL mid_reset_outputs got %h exp 0", {active_valid, in_width, weight_width, remaining, layer_done, err_code, cfg_if.cfg_ready}); else passed++;
        reset = 1'b0;
        tick();
        total++; if ({cfg_if.cfg_ready, active_valid, layer_done} !== 3'b100) $display("FAIL mid_release got %b exp 100", {cfg_if.cfg_ready, active_valid, layer_done}); else passed++;
        step = 1'b1;
        tick();
        step = 1'b0;
        total++; if ({active_valid, layer_done, err_code} !== {1'b0, 1'b0, 4'b1000}) $display("FAIL mid_pending_gone got %b exp 001000", {active_valid, layer_done, err_code}); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_layer();
        test_back_to_back();
        test_finish_direct();
        test_illegal();
        test_idle_step();
        test_reset_mid_layer();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
